// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
//   stageCtrl_t : packed bundle of per-stage stall/flush controls.
//   regW/latW   : width helpers for register index and latency fields.
//   LAT_*       : nominal result latencies of the execution units.
package hazard_pkg;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 3;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic stallW;
    logic flushD;
    logic flushE;
    logic flushW;
  } stageCtrl_t;

  function automatic int regW(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  function automatic int latW(input int maxlat);
    return $clog2(maxlat + 1);
  endfunction

endpackage

// File: rtl/scoreboard_cnt.sv
// scoreboard_cnt: countdown of cycles until one register's pending result
// can be forwarded.
//   clk, reset (async, active-low)
//   freeze : hold the count (memory stall)
//   set    : a new writer of this register issues this cycle
//   setLat : effective latency of that writer (already clamped to 1..MAXLAT)
//   cnt    : cycles remaining; 0 = in register file, 1 = on forward path
module scoreboard_cnt #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          freeze,
  input  logic          set,
  input  logic [LW-1:0] setLat,
  output logic [LW-1:0] cnt
);

  logic [LW-1:0] decCnt;
  logic [LW-1:0] nextCnt;

  // A new writer never shortens an older in-flight write: keep the later
  // of the two completion times so the register is not read early (WAW).
  always_comb begin
    decCnt  = (cnt != '0) ? cnt - LW'(1) : '0;
    nextCnt = decCnt;
    if (set && (setLat > decCnt)) nextCnt = setLat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (!freeze) cnt <= nextCnt;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: latency-scoreboard hazard unit for the pipelined core.
// Tracks, per architectural register, the cycles until its pending result
// is forwardable, and derives all stage stall/flush controls from that,
// the memory-miss stalls and the branch outcome.
//   clk, reset (async, active-low)
//   issue_valid/we/rd/lat : instruction in D requesting issue to E
//   rs_valid, rs_idx      : NRD source-operand ports, port k at [k*RW +: RW]
//   branch_taken_e        : branch resolved taken in E
//   dstall, istall        : data / instruction memory miss
//   stall_f..stall_w      : stage hold enables
//   flush_d, flush_e, flush_w : stage bubble inserts
//   issue_fire            : issue accepted this cycle
//   stall_cycles          : saturating count of cycles with stall_d=1
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int NRD    = 3,
  parameter int MAXLAT = 4,
  parameter int RW     = regW(NREGS),
  parameter int LW     = latW(MAXLAT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [RW-1:0]     issue_rd,
  input  logic [LW-1:0]     issue_lat,
  input  logic [NRD-1:0]    rs_valid,
  input  logic [NRD*RW-1:0] rs_idx,
  input  logic              branch_taken_e,
  input  logic              dstall,
  input  logic              istall,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              issue_fire,
  output logic [31:0]       stall_cycles
);

  logic [LW-1:0] cnt [NREGS];
  logic [LW-1:0] latEff;
  logic          haz;
  logic          issueFire;
  stageCtrl_t    ctrl;
  logic [31:0]   stallCnt;

  // Latency 0 behaves as 1; anything above MAXLAT is clamped.
  always_comb begin
    latEff = issue_lat;
    if (issue_lat == '0)              latEff = LW'(1);
    else if (issue_lat > LW'(MAXLAT)) latEff = LW'(MAXLAT);
  end

  // A source is only blocked while its producer needs more than one cycle;
  // cnt==1 is served by the forward path. Uses pre-update counts, so an
  // instruction reading its own destination sees the older writer.
  always_comb begin
    haz = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      if (rs_valid[k] && (cnt[rs_idx[k*RW +: RW]] > LW'(1))) haz = 1'b1;
    end
  end

  always_comb begin
    ctrl      = '0;
    issueFire = 1'b0;
    if (dstall) begin
      // Whole pipe freezes; the stalled M result must not be written back.
      ctrl.stallF = 1'b1;
      ctrl.stallD = 1'b1;
      ctrl.stallE = 1'b1;
      ctrl.stallM = 1'b1;
      ctrl.stallW = 1'b1;
      ctrl.flushW = 1'b1;
    end else if (branch_taken_e) begin
      // Wrong-path instructions in D and E are squashed; a hazard on a
      // wrong-path instruction is irrelevant.
      ctrl.flushD = 1'b1;
      ctrl.flushE = 1'b1;
    end else if (haz) begin
      ctrl.stallF = 1'b1;
      ctrl.stallD = 1'b1;
      ctrl.flushE = 1'b1;
    end else if (istall) begin
      ctrl.stallF = 1'b1;
      ctrl.flushD = 1'b1;
      issueFire   = issue_valid;
    end else begin
      issueFire   = issue_valid;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : gCnt
      scoreboard_cnt #(.LW(LW)) uCnt (
        .clk    (clk),
        .reset  (reset),
        .freeze (dstall),
        .set    (issueFire && issue_we && (issue_rd == RW'(g))),
        .setLat (latEff),
        .cnt    (cnt[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                stallCnt <= '0;
    else if (ctrl.stallD && (stallCnt != '1))  stallCnt <= stallCnt + 32'd1;
  end

  assign stall_f      = ctrl.stallF;
  assign stall_d      = ctrl.stallD;
  assign stall_e      = ctrl.stallE;
  assign stall_m      = ctrl.stallM;
  assign stall_w      = ctrl.stallW;
  assign flush_d      = ctrl.flushD;
  assign flush_e      = ctrl.flushE;
  assign flush_w      = ctrl.flushW;
  assign issue_fire   = issueFire;
  assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0, issue_we = 1'b0;
  logic [3:0]  issue_rd = '0;
  logic [2:0]  issue_lat = '0;
  logic [2:0]  rs_valid = '0;
  logic [11:0] rs_idx = '0;
  logic        branch_taken_e = 1'b0, dstall = 1'b0, istall = 1'b0;
  logic        stall_f, stall_d, stall_e, stall_m, stall_w;
  logic        flush_d, flush_e, flush_w, issue_fire;
  logic [31:0] stall_cycles;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .rs_valid(rs_valid), .rs_idx(rs_idx),
    .branch_taken_e(branch_taken_e), .dstall(dstall), .istall(istall),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .issue_fire(issue_fire), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] sc;
    int          id;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPass   = 0;
  int   cycleNo = 0;

  // Reference model: each register remembers the absolute progress tick at
  // which its result has fully landed; progress only advances on cycles
  // without a data-memory stall. Remaining latency = readyTick - tick.
  int          readyTick [16];
  int          tick = 0;
  logic [31:0] mStalls = '0;

  function automatic logic [11:0] rsAt(input int port, input int idx);
    logic [11:0] v;
    v = '0;
    v[port*4 +: 4] = 4'(idx);
    return v;
  endfunction

  task automatic step(input logic rst, input logic v, input logic we,
                      input int rd, input int lat,
                      input logic [2:0] rsv, input logic [11:0] rsi,
                      input logic br, input logic ds, input logic is);
    exp_t       e;
    logic       haz;
    logic [8:0] c;
    int         le;
    @(posedge clk); #2;
    reset = rst; issue_valid = v; issue_we = we;
    issue_rd = 4'(rd); issue_lat = 3'(lat);
    rs_valid = rsv; rs_idx = rsi;
    branch_taken_e = br; dstall = ds; istall = is;
    if (!rst) begin
      for (int r = 0; r < 16; r++) readyTick[r] = tick;
      mStalls = '0;
    end
    haz = 1'b0;
    for (int k = 0; k < 3; k++)
      if (rsv[k] && (readyTick[int'(rsi[k*4 +: 4])] - tick > 1)) haz = 1'b1;
    // {stall_f,stall_d,stall_e,stall_m,stall_w,flush_d,flush_e,flush_w,fire}
    if (ds)       c = 9'b111110010;
    else if (br)  c = 9'b000001100;
    else if (haz) c = 9'b110000100;
    else if (is)  c = {8'b10000100, v};
    else          c = {8'b00000000, v};
    e.ctrl = c; e.sc = mStalls; e.id = cycleNo;
    cycleNo++;
    expQ.push_back(e);
    if (rst) begin
      if (c[7] && (mStalls != 32'hFFFF_FFFF)) mStalls = mStalls + 32'd1;
      if (!ds) begin
        if (c[0] && we) begin
          le = (lat == 0) ? 1 : ((lat > 4) ? 4 : lat);
          if (tick + 1 + le > readyTick[rd]) readyTick[rd] = tick + 1 + le;
        end
        tick++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 3'b000, '0, 0, 0, 0);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #4;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nChecks++;
        if ({stall_f, stall_d, stall_e, stall_m, stall_w,
             flush_d, flush_e, flush_w, issue_fire} === e.ctrl) nPass++;
        else $display("FAIL ctrl cycle %0d: got %b expected %b", e.id,
                      {stall_f, stall_d, stall_e, stall_m, stall_w,
                       flush_d, flush_e, flush_w, issue_fire}, e.ctrl);
        nChecks++;
        if (stall_cycles === e.sc) nPass++;
        else $display("FAIL stall_cycles cycle %0d: got %h expected %h",
                      e.id, stall_cycles, e.sc);
      end
    end
  end

  initial begin
    for (int r = 0; r < 16; r++) readyTick[r] = 0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 6; i++)
      step(0, 1'($urandom), 1'($urandom), $urandom_range(0, 15),
           $urandom_range(0, 7), 3'($urandom), 12'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    idle(2);

    // Load-use: one bubble, then the consumer issues.
    step(1, 1, 1, 3, hazard_pkg::LAT_LOAD, 3'b000, '0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 3), 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 3), 0, 0, 0);
    idle(2);

    // ALU result forwarded next cycle, no stall.
    step(1, 1, 1, 5, hazard_pkg::LAT_ALU, 3'b000, '0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'b010, rsAt(1, 5), 0, 0, 0);
    idle(2);

    // Data-memory stall freezes the countdown.
    step(1, 1, 1, 2, hazard_pkg::LAT_MUL, 3'b000, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 3'b100, rsAt(2, 2), 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 3'b100, rsAt(2, 2), 0, 0, 0);
    idle(2);

    // Taken branch overrides a pending hazard and an istall bubble.
    step(1, 1, 1, 9, 4, 3'b000, '0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 9), 1, 0, 1);
    step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 9), 0, 0, 1);
    idle(4);

    // WAW: a short second writer cannot shorten the first.
    step(1, 1, 1, 7, 4, 3'b000, '0, 0, 0, 0);
    step(1, 1, 1, 7, 1, 3'b000, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 7), 0, 0, 0);
    idle(2);

    // Latency clamp (7 -> 4) and latency 0 treated as 1; self-dependence.
    step(1, 1, 1, 6, 7, 3'b000, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 6, 0, 3'b001, rsAt(0, 6), 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 6), 0, 0, 0);
    idle(2);

    // Reset asserted during a hazard stall clears it immediately.
    step(1, 1, 1, 4, 4, 3'b000, '0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 4), 0, 0, 0);
    step(0, 1, 0, 0, 0, 3'b001, rsAt(0, 4), 0, 0, 0);
    step(1, 1, 0, 0, 0, 3'b001, rsAt(0, 4), 0, 0, 0);
    idle(2);

    // Randomised traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
           3'($urandom),
           {1'b0, 3'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom)},
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0);
    idle(6);

    // Saturation: preload near the top, then keep stalling.
    #3;
    force dut.stallCnt = 32'hFFFF_FFFE;
    #1;
    release dut.stallCnt;
    mStalls = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 3'b000, '0, 0, 1, 0);
    idle(2);

    repeat (2) @(posedge clk);
    #6;
    nChecks++;
    if (expQ.size() == 0) nPass++;
    else $display("FAIL queue_drain: got %0d pending required 0", expQ.size());
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed pipelined-core hazard unit.
- Replaces per-stage register-match comparisons with a per-register latency scoreboard; supports NRD decode read ports and variable result latency (ALU, load, multi-cycle).
- Generates all pipeline stall/flush controls, including memory-stall freeze (dstall/istall) and branch flush.
- Adds a saturating stall-cycle performance counter.
- Sits beside the controller/datapath in the core top level; decode-stage issue information in, stage controls out.

Parameters:
- NREGS, 16, architectural registers tracked.
- NRD, 3, decode source-operand ports.
- MAXLAT, 4, maximum result latency in cycles (1 = forwardable next cycle).
- RW, $clog2(NREGS), register index width (derived).
- LW, $clog2(MAXLAT+1), latency field width (derived).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction in D requests issue to E.
- issue_we  in  1  issuing instruction writes a register.
- issue_rd  in  RW  destination register.
- issue_lat  in  LW  cycles until result forwardable (1..MAXLAT; 0 treated as 1).
- rs_valid  in  NRD  source port used.
- rs_idx  in  NRD*RW  source indices, port k at [k*RW +: RW].
- branch_taken_e  in  1  branch resolved taken in E.
- dstall  in  1  data-memory miss.
- istall  in  1  instruction-memory miss.
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  stage hold enables.
- flush_d, flush_e, flush_w  out  1 each  stage bubble inserts.
- issue_fire  out  1  issue accepted this cycle.
- stall_cycles  out  32  saturating count of cycles with stall_d=1.

Behaviour:
- State: cnt[NREGS] (LW bits each), stall_cycles. Reset (reset=0, async): all cnt=0, stall_cycles=0. Outputs are combinational from state/inputs and are all 0 in reset given idle inputs.
- Data hazard: haz = OR over k of (rs_valid[k] && cnt[rs_idx[k]] > 1). cnt==1 means the result is available on the forward path this cycle; cnt==0 means read from the register file.
- Priority, evaluated each cycle:
  - dstall=1: stall_f, stall_d, stall_e, stall_m, stall_w =1; flush_w=1 (no write-back of a stalled M); all other flushes 0; cnt frozen; issue_fire=0.
  - Else branch_taken_e=1: flush_d=1, flush_e=1; no stalls; issue_fire=0. This overrides haz and istall bubbles.
  - Else haz=1: stall_f=1, stall_d=1, flush_e=1; issue_fire=0.
  - Else istall=1: stall_f=1, flush_d=1; issue_fire=issue_valid.
  - Else: issue_fire=issue_valid.
- Counter update (not dstall): every cnt>0 decrements by 1.
  - If issue_fire && issue_we: cnt[issue_rd] = max(lat_eff, cnt[issue_rd]-1), where lat_eff = max(issue_lat,1).
  - The same-register decrement and set in one cycle resolve to the max rule (WAW-safe).
- Self-dependence: an instruction reading its own issue_rd is checked against the pre-update cnt.
- stall_cycles: increments when stall_d=1 (dstall or haz case); saturates at 0xFFFF_FFFF; does not wrap.
- issue_lat > MAXLAT: clamp to MAXLAT.
- Reset mid-stall: all cnt clear immediately; the first cycle after release has no hazards.

Decomposition:
- Package hazard_pkg: stage-control struct (stall/flush bits), LW/RW width helpers, latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=3.
- Sub-module scoreboard_cnt: single-register countdown with set/decrement/freeze, instantiated NREGS times via generate. Hazard priority logic stays in the top.

Test Plan:
- Reset: hold reset=0 with random inputs -> all cnt=0, stall_cycles=0, and no stalls once reset=1 with idle inputs.
- Load-use: issue rd=3, lat=2; next cycle rs_idx[0]=3 valid -> stall_d=stall_f=flush_e=1 for exactly 1 cycle, then issue_fire=1, stall_cycles=1.
- ALU forward: issue rd=5, lat=1; next cycle read r5 -> no stall, issue_fire=1.
- dstall freeze: issue rd=2, lat=3; assert dstall for 4 cycles -> all stalls=1, flush_w=1, cnt[2] holds at 3; after release, reads of r2 stall exactly 2 more cycles.
- Branch over hazard: haz=1 and branch_taken_e=1 together -> flush_d=flush_e=1, stall_d=0, issue_fire=0.
- WAW/saturation: issue rd=7 lat=4, then rd=7 lat=1 -> cnt[7]=3 (max rule). Preload stall_cycles=0xFFFFFFFF via a long stall (force) -> value stays 0xFFFFFFFF.
